sram_sc_arbiter: RTL and testbench

//  Two-port Avalon-MM arbiter sharing the single SRAM_SC master path between the histogram

---
 rtl/sram_sc_arbiter_if.sv | 26 ++
 rtl/sram_sc_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_sc_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_sc_arbiter_if.sv
// Avalon-MM bus bundle shared by both requester ports and the SRAM-side master port.
// Ports: address/read/write/writedata/byteenable flow master->slave;
//        waitrequest/readdata/readdatavalid flow slave->master.
interface sram_sc_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sram_sc_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SRAM_SC slave: port 0 = histogram engine,
// port 1 = host/debug. Round-robin grant, locked while the winner is stalled; a tag FIFO
// steers each readdatavalid beat back to the requester that issued the read.
// Ports: clk_clk, clk_reset_reset (async, active high); s0/s1 requester buses (slave side);
//        m SRAM bus (master side); err_orphan_rdv sticky flag for a return beat with no tag.
module sram_sc_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4
) (
   input  logic                   clk_clk,
   input  logic                   clk_reset_reset,
   sram_sc_arbiter_if.slave       s0,
   sram_sc_arbiter_if.slave       s1,
   sram_sc_arbiter_if.master      m,
   output logic                   err_orphan_rdv
);

   localparam int PW = $clog2(MAX_PENDING);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t                 state;
   logic                   last;      // port granted by the most recent accepted command
   logic [MAX_PENDING-1:0] tag_mem;   // issuing port of each outstanding read
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;

   logic [1:0] req;
   logic [1:0] rd_only;               // read without write; write wins when both are high
   logic [1:0] elig;
   logic       fifo_full;
   logic       fifo_empty;
   logic       gnt_vld;
   logic       gnt;
   logic       accept;
   logic       push;
   logic       pop;
   logic       head;

   logic [ADDR_W-1:0]   sel_address;
   logic [DATA_W-1:0]   sel_writedata;
   logic [DATA_W/8-1:0] sel_byteenable;

   assign req[0]     = s0.read | s0.write;
   assign req[1]     = s1.read | s1.write;
   assign rd_only[0] = s0.read & ~s0.write;
   assign rd_only[1] = s1.read & ~s1.write;
   assign fifo_full  = (count == CW'(MAX_PENDING));
   assign fifo_empty = (count == '0);
   // A read with no free tag slot cannot compete; a pop in the same cycle does not help.
   assign elig       = req & ~(rd_only & {2{fifo_full}});

   always_comb begin
      gnt_vld = 1'b0;
      gnt     = 1'b0;
      case (state)
         IDLE: begin
            if (elig[0] && elig[1]) begin
               gnt_vld = 1'b1;
               gnt     = ~last;
            end else if (elig[0]) begin
               gnt_vld = 1'b1;
               gnt     = 1'b0;
            end else if (elig[1]) begin
               gnt_vld = 1'b1;
               gnt     = 1'b1;
            end
         end
         LOCK0: begin
            gnt_vld = elig[0];
            gnt     = 1'b0;
         end
         LOCK1: begin
            gnt_vld = elig[1];
            gnt     = 1'b1;
         end
         default: begin
            gnt_vld = 1'b0;
            gnt     = 1'b0;
         end
      endcase
      // Nothing reaches the SRAM and every requester stalls while reset is held.
      if (clk_reset_reset) gnt_vld = 1'b0;
   end

   // Forward path: winner's command goes out in the same cycle.
   assign sel_address    = gnt ? s1.address    : s0.address;
   assign sel_writedata  = gnt ? s1.writedata  : s0.writedata;
   assign sel_byteenable = gnt ? s1.byteenable : s0.byteenable;

   assign m.address    = sel_address;
   assign m.writedata  = sel_writedata;
   assign m.byteenable = sel_byteenable;
   assign m.read       = gnt_vld & (gnt ? rd_only[1] : rd_only[0]);
   assign m.write      = gnt_vld & (gnt ? s1.write   : s0.write);

   assign accept = gnt_vld & ~m.waitrequest;
   assign push   = accept & m.read;

   assign s0.waitrequest = (gnt_vld && !gnt) ? m.waitrequest : 1'b1;
   assign s1.waitrequest = (gnt_vld &&  gnt) ? m.waitrequest : 1'b1;

   // Return path: head tag picks the destination; an empty FIFO means an orphan beat.
   assign pop  = m.readdatavalid & ~fifo_empty;
   assign head = tag_mem[rd_ptr];

   assign s0.readdatavalid = pop & ~head;
   assign s1.readdatavalid = pop &  head;
   assign s0.readdata      = m.readdata;
   assign s1.readdata      = m.readdata;

   always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
      if (clk_reset_reset) begin
         state          <= IDLE;
         last           <= 1'b1;
         tag_mem        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         err_orphan_rdv <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld && m.waitrequest) state <= gnt ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
               // Leave on acceptance, or if the owner withdrew its command.
               if (!gnt_vld || !m.waitrequest) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (accept) last <= gnt;

         if (push) begin
            tag_mem[wr_ptr] <= gnt;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);

         if (m.readdatavalid && fifo_empty) err_orphan_rdv <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_sc_arbiter.sv
// Self-checking bench for sram_sc_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model (queue of tags).
module tb_sram_sc_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MAXP   = 4;

   logic clk = 1'b0;
   logic rst;
   logic err_orphan_rdv;

   sram_sc_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s0_if ();
   sram_sc_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s1_if ();
   sram_sc_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

   sram_sc_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
      .clk_clk         (clk),
      .clk_reset_reset (rst),
      .s0              (s0_if),
      .s1              (s1_if),
      .m               (m_if),
      .err_orphan_rdv  (err_orphan_rdv)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: who won last, who holds a stalled grant, FIFO of issuing ports.
   int mdl_last = 1;
   int mdl_lock = -1;
   int mdl_q[$];
   bit mdl_err  = 1'b0;
   int act_gnt;   // port whose command the DUT accepted this cycle (-1 none)

   task automatic set_in(input bit r0, input bit w0, input bit r1, input bit w1,
                         input bit mw, input bit mrdv);
      s0_if.read = r0;  s0_if.write = w0;
      s1_if.read = r1;  s1_if.write = w1;
      s0_if.address = $urandom;  s0_if.writedata = $urandom;
      s1_if.address = $urandom;  s1_if.writedata = $urandom;
      s0_if.byteenable = 4'($urandom_range(0, 15));
      s1_if.byteenable = 4'($urandom_range(0, 15));
      m_if.waitrequest   = mw;
      m_if.readdatavalid = mrdv;
      m_if.readdata      = $urandom;
   endtask

   // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
   task automatic step();
      bit [1:0]    rq, rdo, wr, ok, exp_rdv, exp_cmd;
      int          g;
      bit          full, mw, mrdv;
      logic [67:0] pay0, pay1;
      #1;
      if (rst) begin
         mdl_lock = -1; mdl_q.delete(); mdl_err = 1'b0; mdl_last = 1;
      end
      wr   = {s1_if.write, s0_if.write};
      rq   = {s1_if.read, s0_if.read} | wr;
      rdo  = {s1_if.read, s0_if.read} & ~wr;
      full = (mdl_q.size() == MAXP);
      ok   = rq & ~(rdo & {2{full}});
      g    = -1;
      if (!rst) begin
         if (mdl_lock >= 0) begin
            if (ok[mdl_lock]) g = mdl_lock;
         end else if (ok == 2'b11) g = 1 - mdl_last;
         else if (ok[0]) g = 0;
         else if (ok[1]) g = 1;
      end
      mw   = m_if.waitrequest;
      mrdv = m_if.readdatavalid;

      exp_cmd = 2'b00;
      if (g >= 0) exp_cmd = {rdo[g], wr[g]};
      check("m_cmd", {m_if.read, m_if.write}, exp_cmd);
      pay0 = {s0_if.address, s0_if.writedata, s0_if.byteenable};
      pay1 = {s1_if.address, s1_if.writedata, s1_if.byteenable};
      if (g >= 0)
         check("m_payload", {m_if.address, m_if.writedata, m_if.byteenable},
               (g == 0) ? pay0 : pay1);
      check("waitreq", {s1_if.waitrequest, s0_if.waitrequest},
            {(g == 1) ? mw : 1'b1, (g == 0) ? mw : 1'b1});
      exp_rdv = 2'b00;
      if (mrdv && mdl_q.size() > 0) exp_rdv[mdl_q[0]] = 1'b1;
      check("rdv", {s1_if.readdatavalid, s0_if.readdatavalid}, exp_rdv);
      if (exp_rdv[0]) check("rdata0", s0_if.readdata, m_if.readdata);
      if (exp_rdv[1]) check("rdata1", s1_if.readdata, m_if.readdata);
      check("err", err_orphan_rdv, mdl_err);

      act_gnt = !s0_if.waitrequest ? 0 : (!s1_if.waitrequest ? 1 : -1);

      @(posedge clk);
      if (!rst) begin
         if (mrdv) begin
            if (mdl_q.size() > 0) void'(mdl_q.pop_front());
            else mdl_err = 1'b1;
         end
         if (g >= 0 && !mw) begin
            mdl_last = g;
            if (rdo[g]) mdl_q.push_back(g);
         end
         if (mdl_lock < 0) begin
            if (g >= 0 && mw) mdl_lock = g;
         end else if (g < 0 || !mw) mdl_lock = -1;
      end
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 2 * MAXP && mdl_q.size() > 0; k++) begin
         set_in(0, 0, 0, 0, 0, 1);
         step();
      end
      check("drain_empty", mdl_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int start;
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      step();
      step();
      rst = 1'b0;

      // T1: single write passes straight through
      set_in(0, 1, 0, 0, 0, 0);
      s0_if.address = 32'h10; s0_if.writedata = 32'hA5A5A5A5;
      #1;
      check("t1_m_write", m_if.write, 1'b1);
      check("t1_m_addr", m_if.address, 32'h10);
      check("t1_s0_wait", s0_if.waitrequest, 1'b0);
      step();

      // T3: s1 write stalled 3 cycles with s0 reading alongside, then s0 gets through
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 0, 1, (i < 3), 0);
         #1;
         check("t3_m_write_s1", m_if.write, 1'b1);
         check("t3_s0_stall", s0_if.waitrequest, 1'b1);
         step();
      end
      set_in(1, 0, 0, 0, 0, 0);
      #1;
      check("t3_s0_granted", s0_if.waitrequest, 1'b0);
      step();

      // T2: both ports read every cycle; grants must alternate, beats go to issuers
      start = 1 - mdl_last;
      for (int i = 0; i < 6; i++) begin
         set_in(1, 0, 1, 0, 0, (i >= 2));
         step();
         check("t2_order", act_gnt, start ^ (i & 1));
      end
      drain();

      // T4: fifth outstanding read stalls until a beat frees a slot
      for (int i = 0; i < MAXP; i++) begin
         set_in(1, 0, 0, 0, 0, 0);
         step();
      end
      set_in(1, 0, 0, 0, 0, 0);
      #1;
      check("t4_full_stall", s0_if.waitrequest, 1'b1);
      check("t4_no_read", m_if.read, 1'b0);
      step();
      set_in(1, 0, 0, 0, 0, 1);
      step();
      set_in(1, 0, 0, 0, 0, 0);
      #1;
      check("t4_fifth_acc", s0_if.waitrequest, 1'b0);
      step();
      drain();

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         bit [2:0] c0, c1;
         c0 = 3'($urandom_range(0, 7));
         c1 = 3'($urandom_range(0, 7));
         set_in(c0 == 1 || c0 == 2 || c0 == 7, c0 == 3 || c0 == 4 || c0 == 7,
                c1 == 1 || c1 == 2 || c1 == 7, c1 == 3 || c1 == 4 || c1 == 7,
                $urandom_range(0, 99) < 30,
                mdl_q.size() > 0 && $urandom_range(0, 99) < 40);
         step();
      end
      drain();

      // T5: orphan beat sets the sticky error
      set_in(0, 0, 0, 0, 0, 1);
      #1;
      check("t5_no_rdv", {s1_if.readdatavalid, s0_if.readdatavalid}, 2'b00);
      step();
      check("t5_err_set", err_orphan_rdv, 1'b1);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1, 1, 0, 0, 0);
         step();
      end

      // T6: reset with reads outstanding drops them; a late beat is an orphan
      set_in(1, 0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b1;
      #1;
      check("t6_err_clr", err_orphan_rdv, 1'b0);
      check("t6_wait", {s1_if.waitrequest, s0_if.waitrequest}, 2'b11);
      step();
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 1);
      step();
      check("t6_late_orphan", err_orphan_rdv, 1'b1);
      set_in(0, 0, 0, 0, 0, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
